// File: rtl/wb_stage_mc_if.sv
// Writeback-stage bundle: stage-2 transfer inputs, load response, RF/CSR writeback outputs.
// Latency: none, wires only.
// Backpressure: stall flows back to the master, which must hold its inputs while it is high.
interface wb_stage_mc_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_alu_out;
    logic            in_jump;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_data;
    logic            stall;
    logic            pc_sel;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            csr_we;
    logic [XLEN-1:0] csr_tohost;
    logic            load_timeout;

    modport master (
        output in_valid, in_pc, in_inst, in_alu_out, in_jump, mem_resp_valid, mem_resp_data,
        input  stall, pc_sel, rf_we, rf_waddr, rf_wdata, csr_we, csr_tohost, load_timeout
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_alu_out, in_jump, mem_resp_valid, mem_resp_data,
        output stall, pc_sel, rf_we, rf_waddr, rf_wdata, csr_we, csr_tohost, load_timeout
    );
endinterface

// File: rtl/wb_stage_mc.sv
// Writeback stage: decodes the retiring instruction, selects PC+4 / ALU / extended load data, drives RF and tohost CSR.
// Latency: 1 cycle for non-loads and same-cycle load responses; loads otherwise retire on the response edge.
// Backpressure: combinational stall while a load waits for its response, bounded by LOAD_TIMEOUT.
module wb_stage_mc #(
    parameter int          XLEN         = 32,
    parameter logic [11:0] TOHOST_ADDR  = 12'h51E,
    parameter int          LOAD_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    wb_stage_mc_if.slave wb
);
    localparam int OFFW  = $clog2(XLEN / 8);
    localparam int CNT_W = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t           state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [4:0]       cap_rd, nxt_cap_rd;
    logic [2:0]       cap_f3, nxt_cap_f3;
    logic [OFFW-1:0]  cap_off, nxt_cap_off;
    logic             rf_we_q, nxt_rf_we;
    logic [4:0]       rf_waddr_q, nxt_rf_waddr;
    logic [XLEN-1:0]  rf_wdata_q, nxt_rf_wdata;
    logic             csr_we_q, nxt_csr_we;
    logic [XLEN-1:0]  csr_tohost_q, nxt_csr_tohost;
    logic             timeout_q, nxt_timeout;
    logic             stall_c;

    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [2:0]       f3;
    logic             is_load, is_jump, is_alu, is_csr, has_wb;
    logic [XLEN-1:0]  wb_data;

    // Shift the aligned word down to the addressed lane, then extend by access size.
    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw,
                                                 input logic [2:0]      fn,
                                                 input logic [OFFW-1:0] off);
        logic [OFFW-1:0] off_eff;
        logic [XLEN-1:0] sh;
        off_eff = off;
        case (fn)
            3'b001, 3'b101: off_eff = off & ~OFFW'(1);
            3'b010:         off_eff = off & ~OFFW'(3);
            3'b110:         off_eff = (XLEN == 64) ? (off & ~OFFW'(3)) : off;
            3'b011:         off_eff = (XLEN == 64) ? '0 : off;
            default:        off_eff = off;
        endcase
        sh = raw >> {off_eff, 3'b000};
        case (fn)
            3'b000:  load_ext = XLEN'($signed(sh[7:0]));
            3'b100:  load_ext = XLEN'(sh[7:0]);
            3'b001:  load_ext = XLEN'($signed(sh[15:0]));
            3'b101:  load_ext = XLEN'(sh[15:0]);
            3'b010:  load_ext = XLEN'($signed(sh[31:0]));
            3'b110:  load_ext = (XLEN == 64) ? XLEN'(sh[31:0]) : XLEN'(sh[7:0]);
            3'b011:  load_ext = (XLEN == 64) ? sh : XLEN'(sh[7:0]);
            default: load_ext = XLEN'(sh[7:0]);
        endcase
    endfunction

    assign opcode  = wb.in_inst[6:0];
    assign rd      = wb.in_inst[11:7];
    assign f3      = wb.in_inst[14:12];
    assign is_load = (opcode == OPC_LOAD);
    assign is_jump = (opcode == OPC_JAL) || (opcode == OPC_JALR);
    assign is_alu  = (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_OP) ||
                     (opcode == OPC_OPIMM) ||
                     ((XLEN == 64) && ((opcode == OPC_OP32) || (opcode == OPC_OPIMM32)));
    assign is_csr  = (opcode == OPC_SYSTEM) && ((f3 == 3'b001) || (f3 == 3'b101)) &&
                     (wb.in_inst[31:20] == TOHOST_ADDR);
    assign has_wb  = is_load || is_jump || is_alu;
    assign wb_data = is_jump ? (wb.in_pc + XLEN'(4)) :
                     is_load ? load_ext(wb.mem_resp_data, f3, wb.in_alu_out[OFFW-1:0]) :
                               wb.in_alu_out;

    always_comb begin
        nxt_state      = state;
        nxt_cnt        = cnt;
        nxt_cap_rd     = cap_rd;
        nxt_cap_f3     = cap_f3;
        nxt_cap_off    = cap_off;
        nxt_rf_we      = 1'b0;
        nxt_rf_waddr   = rf_waddr_q;
        nxt_rf_wdata   = rf_wdata_q;
        nxt_csr_we     = 1'b0;
        nxt_csr_tohost = csr_tohost_q;
        nxt_timeout    = timeout_q;
        stall_c        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wb.in_valid) begin
                    if (is_load && !wb.mem_resp_valid) begin
                        stall_c     = 1'b1;
                        nxt_state   = ST_WAIT;
                        nxt_cnt     = '0;
                        nxt_cap_rd  = rd;
                        nxt_cap_f3  = f3;
                        nxt_cap_off = wb.in_alu_out[OFFW-1:0];
                    end else if (has_wb && (rd != 5'd0)) begin
                        nxt_rf_we    = 1'b1;
                        nxt_rf_waddr = rd;
                        nxt_rf_wdata = wb_data;
                    end
                    if (is_csr) begin
                        nxt_csr_we     = 1'b1;
                        nxt_csr_tohost = f3[2] ? XLEN'(wb.in_inst[19:15]) : wb.in_alu_out;
                    end
                end
            end
            ST_WAIT: begin
                if (wb.mem_resp_valid) begin
                    nxt_state = ST_IDLE;
                    if (cap_rd != 5'd0) begin
                        nxt_rf_we    = 1'b1;
                        nxt_rf_waddr = cap_rd;
                        nxt_rf_wdata = load_ext(wb.mem_resp_data, cap_f3, cap_off);
                    end
                end else begin
                    stall_c = 1'b1;
                    // Leaving on this edge means the counter would have reached LOAD_TIMEOUT-1.
                    if (cnt == CNT_W'(LOAD_TIMEOUT - 2)) begin
                        nxt_state   = ST_IDLE;
                        nxt_timeout = 1'b1;
                    end else begin
                        nxt_cnt = cnt + CNT_W'(1);
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            cap_rd       <= '0;
            cap_f3       <= '0;
            cap_off      <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            csr_we_q     <= 1'b0;
            csr_tohost_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state        <= nxt_state;
            cnt          <= nxt_cnt;
            cap_rd       <= nxt_cap_rd;
            cap_f3       <= nxt_cap_f3;
            cap_off      <= nxt_cap_off;
            rf_we_q      <= nxt_rf_we;
            rf_waddr_q   <= nxt_rf_waddr;
            rf_wdata_q   <= nxt_rf_wdata;
            csr_we_q     <= nxt_csr_we;
            csr_tohost_q <= nxt_csr_tohost;
            timeout_q    <= nxt_timeout;
        end
    end

    assign wb.stall        = stall_c;
    assign wb.pc_sel       = wb.in_valid && wb.in_jump && (state == ST_IDLE);
    assign wb.rf_we        = rf_we_q;
    assign wb.rf_waddr     = rf_waddr_q;
    assign wb.rf_wdata     = rf_wdata_q;
    assign wb.csr_we       = csr_we_q;
    assign wb.csr_tohost   = csr_tohost_q;
    assign wb.load_timeout = timeout_q;
endmodule

// File: doc/wb_stage_mc.md
Name: wb_stage_mc

Overview:
Parametrised successor to the pipeline's writeback stage. Decodes the retiring instruction and selects writeback data from PC+4, ALU result or load data. Load responses may arrive with variable latency; the block stalls upstream meanwhile and extracts/extends sub-word load data. It registers the register-file write and holds a tohost CSR. Sits between stage-2 transfer registers and the register file / CSR path.

Parameters:
XLEN, 32, datapath width; 32 or 64 only.
TOHOST_ADDR, 12'h51E, CSR address written by csrrw/csrrwi.
LOAD_TIMEOUT, 16, max wait cycles for a load response; must be >= 2.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
in_valid  in  1  instruction present this cycle.
in_pc  in  XLEN  PC of the instruction.
in_inst  in  32  instruction word.
in_alu_out  in  XLEN  ALU result; load/store address for memory ops.
in_jump  in  1  branch taken / jump resolved.
mem_resp_valid  in  1  load data valid this cycle.
mem_resp_data  in  XLEN  raw aligned memory word.
stall  out  1  upstream must hold inputs (combinational).
pc_sel  out  1  select ALU target for next PC (combinational).
rf_we  out  1  register write enable, one-cycle pulse.
rf_waddr  out  5  destination register.
rf_wdata  out  XLEN  writeback data.
csr_we  out  1  tohost write pulse.
csr_tohost  out  XLEN  tohost CSR value.
load_timeout  out  1  sticky: a load response never arrived.

Behaviour:
- Reset (async, reset_n=0): state IDLE, wait counter 0, rf_we=0, rf_waddr=0, rf_wdata=0, csr_we=0, csr_tohost=0, load_timeout=0. Asserting reset mid-WAIT aborts the load; no write is issued.
- States: IDLE, WAIT.
- Decode on opcode inst[6:0]:
  - JAL/JALR: data = in_pc+4, XLEN-bit wrap.
  - LUI/AUIPC/OP/OP-IMM (XLEN=64 also OP-32/OP-IMM-32): data = in_alu_out.
  - LOAD: data = extended load data.
  - SYSTEM funct3 001 (csrrw) / 101 (csrrwi) with inst[31:20]==TOHOST_ADDR: no rf write. Next edge: csr_tohost = in_alu_out (csrrw) or zero-extended inst[19:15] (csrrwi); csr_we=1 for one cycle.
  - Store/branch/other: no write.
- rf_we forced 0 when inst[11:7]==0.
- pc_sel = in_valid & in_jump & (state==IDLE).
- Non-load in IDLE with in_valid: rf_we/rf_waddr/rf_wdata register at the next edge (latency 1).
- Load in IDLE:
  - If mem_resp_valid is also high, complete as a non-load, latency 1.
  - Otherwise capture rd, funct3 and low address bits, go to WAIT, counter=0.
- stall = (IDLE & in_valid & is_load & !mem_resp_valid) | (WAIT & !mem_resp_valid).
- WAIT:
  - Inputs other than mem_resp_* are ignored.
  - On mem_resp_valid: register the write at that edge, return to IDLE; stall=0 in the response cycle.
  - Otherwise the counter increments each cycle. When it reaches LOAD_TIMEOUT-1 with no response: set load_timeout (sticky until reset), return to IDLE, no write.
- Load extraction. Offset = alu_out[log2(XLEN/8)-1:0]; data is shifted right by 8*offset.
  - LB/LBU (000/100): sign-/zero-extend byte.
  - LH/LHU (001/101): sign-/zero-extend half; offset bit 0 ignored.
  - LW (010): sign-extend word (XLEN=64); offset bits [1:0] ignored.
  - XLEN=64 only: LWU (110) zero-extends word; LD (011) uses the full word.
  - Other funct3: zero-extended byte.
- rf_we and csr_we are single-cycle pulses; other outputs hold their last value.

Test Plan:
- ADDI rd=5, alu_out=0x1234, in_valid=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x00001234; stall=0 throughout.
- LB rd=7, alu_out=0x1003, mem_resp_valid 3 cycles later with data 0x80FF0000 -> stall high exactly 3 cycles; then rf_wdata=0xFFFFFF80, rf_waddr=7. LBU same -> 0x00000080.
- JAL rd=1, pc=0xFFFFFFFC, in_jump=1 -> pc_sel=1 same cycle; next cycle rf_wdata=0x00000000 (wrap). ADDI rd=0 -> rf_we stays 0.
- csrrwi csr=0x51E, zimm=17 -> csr_we pulse, csr_tohost=0x00000011, rf_we=0. csrrw with alu_out=0xDEAD -> csr_tohost=0x0000DEAD.
- LOAD_TIMEOUT=16, load with no response -> stall high for the capture cycle plus 15 WAIT cycles; load_timeout=1 and stays 1; no rf_we; next ADDI writes normally.
- Reset_n pulsed low during WAIT -> all outputs 0 immediately, state IDLE; a late mem_resp_valid produces no write. XLEN=64 LWU offset 4, data 0x89ABCDEF_01234567 -> rf_wdata=0x0000000089ABCDEF.
